// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - mode encodings and legality check shared by the barrel shifter pipeline
package shifter_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        SHIFT_SLL = 3'b000,
        SHIFT_SRL = 3'b001,
        SHIFT_SRA = 3'b010,
        SHIFT_ROL = 3'b011,
        SHIFT_ROR = 3'b100
    } shift_mode_e;

    function automatic logic is_legal_mode(input logic [MODE_W-1:0] mode);
        return (mode <= SHIFT_ROR);
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// rtl/shifter_stage.sv - one pipeline stage: conditional shift/rotate by 2^K plus its register
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int K     = 0,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              i_valid,
    input  logic [WIDTH-1:0]  i_data,
    input  logic [SHW-1:0]    i_shamt,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_err,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [WIDTH-1:0]  o_data,
    output logic [SHW-1:0]    o_shamt,
    output logic [MODE_W-1:0] o_mode,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_err
);

    localparam int DIST = 1 << K;

    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [SHW-1:0]    r_shamt;
    logic [MODE_W-1:0] r_mode;
    logic [TAG_W-1:0]  r_tag;
    logic              r_err;

    logic              w_load;
    logic [WIDTH-1:0]  w_shifted;

    assign w_load = !r_valid || i_ready;

    // SRA refills from the current MSB, which earlier stages never disturb, so it stays the operand sign
    always_comb begin
        w_shifted = i_data;
        if (!is_legal_mode(i_mode)) begin
            w_shifted = '0;
        end else if (i_shamt[K]) begin
            case (i_mode)
                SHIFT_SLL: w_shifted = {i_data[WIDTH-1-DIST:0], {DIST{1'b0}}};
                SHIFT_SRL: w_shifted = {{DIST{1'b0}}, i_data[WIDTH-1:DIST]};
                SHIFT_SRA: w_shifted = {{DIST{i_data[WIDTH-1]}}, i_data[WIDTH-1:DIST]};
                SHIFT_ROL: w_shifted = {i_data[WIDTH-1-DIST:0], i_data[WIDTH-1:WIDTH-DIST]};
                SHIFT_ROR: w_shifted = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
                default:   w_shifted = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_shamt <= '0;
            r_mode  <= SHIFT_SLL;
            r_tag   <= '0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data  <= w_shifted;
                r_shamt <= i_shamt;
                r_mode  <= i_mode;
                r_tag   <= i_tag;
                r_err   <= i_err;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_shamt = r_shamt;
    assign o_mode  = r_mode;
    assign o_tag   = r_tag;
    assign o_err   = r_err;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - SHW-stage pipelined shift/rotate unit with valid/ready on both sides
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SHW-1:0]    in_shamt,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    // Index 0 is the input side; index k+1 is the register output of stage k
    logic [SHW:0]      w_valid;
    logic [SHW:0]      w_ready;
    logic [WIDTH-1:0]  w_data  [0:SHW];
    logic [SHW-1:0]    w_shamt [0:SHW];
    logic [MODE_W-1:0] w_mode  [0:SHW];
    logic [TAG_W-1:0]  w_tag   [0:SHW];
    logic              w_err   [0:SHW];
    logic              w_legal;
    logic              w_unused_tail;

    assign w_legal    = is_legal_mode(in_mode);
    assign w_valid[0] = in_valid;
    assign w_data[0]  = w_legal ? in_data : '0;
    assign w_shamt[0] = in_shamt;
    assign w_mode[0]  = in_mode;
    assign w_tag[0]   = in_tag;
    assign w_err[0]   = !w_legal;

    assign w_ready[SHW] = out_ready;

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            // Unrolled form of ready_k = !valid_k | ready_(k+1); avoids a combinational chain through one vector
            assign w_ready[k] = out_ready || !(&w_valid[SHW:k+1]);

            shifter_stage #(
                .WIDTH (WIDTH),
                .TAG_W (TAG_W),
                .K     (k)
            ) u_stage (
                .clock        (clock),
                .ctrl_reset_n (ctrl_reset_n),
                .i_valid      (w_valid[k]),
                .i_data       (w_data[k]),
                .i_shamt      (w_shamt[k]),
                .i_mode       (w_mode[k]),
                .i_tag        (w_tag[k]),
                .i_err        (w_err[k]),
                .i_ready      (w_ready[k+1]),
                .o_valid      (w_valid[k+1]),
                .o_data       (w_data[k+1]),
                .o_shamt      (w_shamt[k+1]),
                .o_mode       (w_mode[k+1]),
                .o_tag        (w_tag[k+1]),
                .o_err        (w_err[k+1])
            );
        end
    endgenerate

    assign in_ready      = w_ready[0];
    assign out_valid     = w_valid[SHW];
    assign out_data      = w_data[SHW];
    assign out_tag       = w_tag[SHW];
    assign out_err       = w_err[SHW];
    assign w_unused_tail = ^{w_shamt[SHW], w_mode[SHW]};

endmodule
